// File: rtl/fwd_hazard_sb_if.sv
// Decode-side bus between the issue stage and the forwarding/hazard unit.
// Parameters AW and DEPTH must match the ones given to fwd_hazard_sb.
//
// Handshake: the issue stage (master) presents one instruction per cycle
// with id_valid. The hazard unit (slave) accepts it on a rising edge when
// stall is low and flush is low. While stall is high the master holds every
// id_* field stable, and EX receives a bubble. flush drops the instruction
// unconditionally and takes priority over stall. byp_rs/byp_rt qualify the
// same-cycle operands. fwd_rs/fwd_rt belong to whatever instruction sits
// in EX in the current cycle.
interface fwd_hazard_sb_if #(
   parameter int AW    = 5,
   parameter int DEPTH = 3
);
   localparam int FW = $clog2(DEPTH);

   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic [AW-1:0] id_rd;
   logic          id_regwr;
   logic          id_load;
   logic          flush;
   logic          stall;
   logic          byp_rs;
   logic          byp_rt;
   logic [FW-1:0] fwd_rs;
   logic [FW-1:0] fwd_rt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_rd, id_regwr, id_load, flush,
      input  stall, byp_rs, byp_rt, fwd_rs, fwd_rt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_rd, id_regwr, id_load, flush,
      output stall, byp_rs, byp_rt, fwd_rs, fwd_rt
   );
endinterface

// File: rtl/fwd_hazard_sb.sv
// Forwarding and load-use hazard unit for the in-order integer pipeline.
// It keeps a scoreboard of in-flight register writes, one entry per
// post-decode stage (stage 1 = EX, stage DEPTH = WB). From that scoreboard
// it produces the registered EX forwarding selects, the combinational
// WB->decode bypass flags, and the load-use stall.
// Optional feature: define FWD_PERF_CNT_EN to add the 32-bit stall_cnt port.
module fwd_hazard_sb #(
   parameter  int AW         = 5,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 2,
   localparam int FW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fwd_hazard_sb_if.slave        bus
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   typedef struct packed {
      logic          v;
      logic          wr;
      logic [AW-1:0] rd;
      logic          ld;
   } sb_entry_t;

   // sb[i] describes the instruction in post-decode stage i.
   sb_entry_t sb [1:DEPTH];

   int            idx_rs;
   int            idx_rt;
   logic          ld_rs;
   logic          ld_rt;
   logic          haz_rs;
   logic          haz_rt;
   logic          stall_int;
   logic [FW-1:0] nxt_fwd_rs;
   logic [FW-1:0] nxt_fwd_rt;

   // Find the youngest matching producer per source; scanning from oldest to
   // youngest lets the youngest match overwrite older ones. 0 means no match.
   always_comb begin
      idx_rs = 0;
      idx_rt = 0;
      ld_rs  = 1'b0;
      ld_rt  = 1'b0;
      for (int i = DEPTH; i >= 1; i--) begin
         if (bus.id_valid && bus.id_use_rs && (bus.id_rs != '0) &&
             sb[i].v && sb[i].wr && (sb[i].rd == bus.id_rs)) begin
            idx_rs = i;
            ld_rs  = sb[i].ld;
         end
         if (bus.id_valid && bus.id_use_rt && (bus.id_rt != '0) &&
             sb[i].v && sb[i].wr && (sb[i].rd == bus.id_rt)) begin
            idx_rt = i;
            ld_rt  = sb[i].ld;
         end
      end
   end

   // A load still in a stage before its data register is a hazard. A WB
   // match is served by the bypass, so it does not get an EX select.
   always_comb begin
      haz_rs     = (idx_rs != 0) && ld_rs && (idx_rs < LOAD_STAGE);
      haz_rt     = (idx_rt != 0) && ld_rt && (idx_rt < LOAD_STAGE);
      stall_int  = (haz_rs || haz_rt) && !bus.flush;
      nxt_fwd_rs = '0;
      nxt_fwd_rt = '0;
      if ((idx_rs != 0) && (idx_rs < DEPTH) && !haz_rs) nxt_fwd_rs = FW'(idx_rs);
      if ((idx_rt != 0) && (idx_rt < DEPTH) && !haz_rt) nxt_fwd_rt = FW'(idx_rt);
   end

   assign bus.stall  = stall_int;
   assign bus.byp_rs = (idx_rs == DEPTH);
   assign bus.byp_rt = (idx_rt == DEPTH);

   // Scoreboard advances every cycle. flush drops the stage-1 entry and the
   // decode instruction; a stalled decode instruction is replaced by a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= DEPTH; i++) sb[i] <= '0;
      end else begin
         for (int i = DEPTH; i >= 3; i--) sb[i] <= sb[i-1];
         sb[2] <= bus.flush ? '0 : sb[1];
         if (bus.id_valid && !stall_int && !bus.flush)
            sb[1] <= '{v: 1'b1, wr: bus.id_regwr, rd: bus.id_rd, ld: bus.id_load};
         else
            sb[1] <= '0;
      end
   end

   // EX operand selects follow the instruction into EX; a bubble gets 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fwd_rs <= '0;
         bus.fwd_rt <= '0;
      end else if (stall_int || bus.flush) begin
         bus.fwd_rs <= '0;
         bus.fwd_rt <= '0;
      end else begin
         bus.fwd_rs <= nxt_fwd_rs;
         bus.fwd_rt <= nxt_fwd_rt;
      end
   end

`ifdef FWD_PERF_CNT_EN
   // Count stall cycles; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         stall_cnt <= '0;
      else if (stall_int) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_sb.sv
// Self-checking bench for fwd_hazard_sb with default parameters
// (DEPTH = 3, LOAD_STAGE = 2). Expected EX selects are queued when an
// instruction is presented and compared one cycle later.
module tb_fwd_hazard_sb;
   localparam int AW         = 5;
   localparam int DEPTH      = 3;
   localparam int LOAD_STAGE = 2;
   localparam int FW         = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fwd_hazard_sb_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   fwd_hazard_sb #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FWD_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [2*FW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic idle_inputs();
      bus.id_valid  = 1'b0;
      bus.id_rs     = '0;
      bus.id_rt     = '0;
      bus.id_use_rs = 1'b0;
      bus.id_use_rt = 1'b0;
      bus.id_rd     = '0;
      bus.id_regwr  = 1'b0;
      bus.id_load   = 1'b0;
      bus.flush     = 1'b0;
   endtask

   // One decode cycle: drive, check combinational outputs mid-cycle, then
   // check the registered selects after the edge.
   task automatic cyc(input string name, input int v, input int rs, input int urs,
                      input int rt, input int urt, input int rd, input int wr,
                      input int ld, input int fl, input int e_stall,
                      input int e_brs, input int e_brt, input int e_frs, input int e_frt);
      logic [2*FW-1:0] e;
      bus.id_valid  = v[0];
      bus.id_rs     = rs[AW-1:0];
      bus.id_use_rs = urs[0];
      bus.id_rt     = rt[AW-1:0];
      bus.id_use_rt = urt[0];
      bus.id_rd     = rd[AW-1:0];
      bus.id_regwr  = wr[0];
      bus.id_load   = ld[0];
      bus.flush     = fl[0];
      exp_q.push_back({e_frs[FW-1:0], e_frt[FW-1:0]});
      @(negedge clk);
      chk({name, ".stall"},  32'(bus.stall),  e_stall);
      chk({name, ".byp_rs"}, 32'(bus.byp_rs), e_brs);
      chk({name, ".byp_rt"}, 32'(bus.byp_rt), e_brt);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({name, ".fwd_rs"}, 32'(bus.fwd_rs), 32'(e[2*FW-1:FW]));
      chk({name, ".fwd_rt"}, 32'(bus.fwd_rt), 32'(e[FW-1:0]));
   endtask

   task automatic nop(input string name);
      cyc(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH; i++) nop("drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int o;
      // clock/reset block
      idle_inputs();
      rst_n = 1'b0;
      #2;
      chk("rst.stall",  32'(bus.stall),  0);
      chk("rst.byp_rs", 32'(bus.byp_rs), 0);
      chk("rst.byp_rt", 32'(bus.byp_rt), 0);
      chk("rst.fwd_rs", 32'(bus.fwd_rs), 0);
      chk("rst.fwd_rt", 32'(bus.fwd_rt), 0);
`ifdef FWD_PERF_CNT_EN
      chk("rst.stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU back-to-back: add r3 ; sub r4, r3, r5
      cyc("alu_add", 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("alu_sub", 1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0);
      drain();

      // Load-use: lw r2 ; add r6, r2, r2 stalls one cycle then gets fwd 2
      cyc("lu_lw",   1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("lu_stl",  1, 2, 1, 2, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0);
      cyc("lu_go",   1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0, 0, 2, 2);
      drain();

      // Priority: two writes of r7, consumer takes the youngest
      cyc("pri_w1",  1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("pri_w2",  1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc("pri_use", 1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 1, 1);
      drain();

      // WB bypass: consumer three cycles after the write
      cyc("wb_w",    1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      nop("wb_n1");
      nop("wb_n2");
      cyc("wb_use",  1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      // Load already in WB: bypass, no stall
      cyc("wbl_lw",  1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0);
      nop("wbl_n1");
      nop("wbl_n2");
      cyc("wbl_use", 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // Load in stage 2: forwarded from the load data register
      cyc("s2_lw",   1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0);
      nop("s2_n1");
      cyc("s2_use",  1, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      drain();

      // r0 never matches
      cyc("r0_w",    1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r0_use",  1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      drain();
      cyc("r0_lw",   1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("r0_luse", 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Use masks and id_valid gate the match
      cyc("m_lw",    1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("m_rt0",   1, 11, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();
      cyc("m_lw2",   1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("m_rs0",   1, 10, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();
      cyc("m_lw3",   1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("m_inv",   0, 10, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Flush beats a load-use hazard; the load in stage 1 is also killed
      cyc("fl_lw",   1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("fl_haz",  1, 2, 1, 2, 1, 12, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc("fl_next", 1, 2, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();
      // Flush zeroes a would-be forward and clears the ALU producer
      cyc("fl_add",  1, 1, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("fl_kill", 1, 13, 1, 0, 0, 14, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc("fl_rd",   1, 13, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Reset in the middle of a stall, with a live forward in EX
      cyc("mr_add",  1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("mr_lw",   1, 3, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 1, 0);
      bus.id_valid  = 1'b1;
      bus.id_rs     = 5'd2;
      bus.id_use_rs = 1'b1;
      bus.id_rt     = 5'd2;
      bus.id_use_rt = 1'b1;
      bus.id_rd     = 5'd6;
      bus.id_regwr  = 1'b1;
      bus.id_load   = 1'b0;
      @(negedge clk);
      chk("mr_pre.stall",  32'(bus.stall),  1);
      chk("mr_pre.fwd_rs", 32'(bus.fwd_rs), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_rst.stall",  32'(bus.stall),  0);
      chk("mr_rst.fwd_rs", 32'(bus.fwd_rs), 0);
      chk("mr_rst.fwd_rt", 32'(bus.fwd_rt), 0);
`ifdef FWD_PERF_CNT_EN
      chk("mr_rst.stall_cnt", stall_cnt, 0);
`endif
      idle_inputs();
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc("mr_after", 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Three load-use events on random registers
      for (int k = 0; k < 3; k++) begin
         r = $urandom_range(1, 31);
         o = (r == 31) ? 1 : r + 1;
         cyc("rl_lw",  1, 0, 0, 0, 0, r, 1, 1, 0, 0, 0, 0, 0, 0);
         cyc("rl_stl", 1, r, 1, o, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
         cyc("rl_go",  1, r, 1, o, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
         drain();
      end
`ifdef FWD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, 3);
`endif

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
